// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit: forwarding-mux
// encodings, memory wait-state FSM states and the hard-wired zero register.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF     = 2'd0,
    FWD_EX_MEM = 2'd1,
    FWD_MEM_WB = 2'd2
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_fsm_e;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count state: clear first, then hold at all-ones once saturated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: hazard stalls, operand forwarding,
// branch flush, data-memory wait states and saturating performance counters.
module pipe_ctrl #(
  parameter int REG_IDX_W = 5,
  parameter int MEM_LAT   = 1,
  parameter int FWD_EN    = 1,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] if_id_rs1_idx,
  input  logic [REG_IDX_W-1:0] if_id_rs2_idx,
  input  logic                 if_id_rs1_used,
  input  logic                 if_id_rs2_used,
  input  logic                 if_id_valid,
  input  logic [REG_IDX_W-1:0] id_ex_rs1_idx,
  input  logic [REG_IDX_W-1:0] id_ex_rs2_idx,
  input  logic [REG_IDX_W-1:0] id_ex_dest_idx,
  input  logic                 id_ex_reg_wr,
  input  logic                 id_ex_rd_mem,
  input  logic                 id_ex_valid,
  input  logic                 ex_take_branch,
  input  logic [REG_IDX_W-1:0] ex_mem_dest_idx,
  input  logic                 ex_mem_reg_wr,
  input  logic                 ex_mem_rd_mem,
  input  logic                 ex_mem_wr_mem,
  input  logic                 ex_mem_valid,
  input  logic [REG_IDX_W-1:0] mem_wb_dest_idx,
  input  logic                 mem_wb_reg_wr,
  input  logic                 mem_wb_valid,
  input  logic                 cnt_clr,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 mem_wb_bubble,
  output logic [1:0]           fwd_a_sel,
  output logic [1:0]           fwd_b_sel,
  output logic                 mem_stall,
  output logic [CNT_W-1:0]     cnt_cycles,
  output logic [CNT_W-1:0]     cnt_retired,
  output logic [CNT_W-1:0]     cnt_stall,
  output logic [CNT_W-1:0]     cnt_flush
);

  import pipe_ctrl_pkg::*;

  localparam int REM_W = $clog2(MEM_LAT) + 1;
  localparam logic [REM_W-1:0] REM_INIT = (MEM_LAT > 1) ? REM_W'(MEM_LAT - 2) : '0;
  localparam logic [REG_IDX_W-1:0] ZERO_IDX = REG_IDX_W'(ZERO_REG);

  mem_fsm_e         state_r;
  logic [REM_W-1:0] rem_r;
  logic             mem_access_s;
  logic             mem_stall_s;
  logic             load_use_s;
  logic             raw_s;
  logic             branch_s;
  logic             hz_stall_s;

  function automatic logic idx_hit(input logic [REG_IDX_W-1:0] a,
                                   input logic [REG_IDX_W-1:0] b);
    return (a == b) && (a != ZERO_IDX);
  endfunction

  // True when a used source of the ID instruction reads register dest.
  function automatic logic src_hit(input logic                 vld,
                                   input logic [REG_IDX_W-1:0] rs1,
                                   input logic                 rs1_used,
                                   input logic [REG_IDX_W-1:0] rs2,
                                   input logic                 rs2_used,
                                   input logic [REG_IDX_W-1:0] dest);
    return vld && ((rs1_used && idx_hit(rs1, dest)) || (rs2_used && idx_hit(rs2, dest)));
  endfunction

  // Newest producer wins: EX/MEM ALU result beats MEM/WB write data.
  function automatic fwd_sel_e fwd_pick(input logic [REG_IDX_W-1:0] src,
                                        input logic                 em_vld,
                                        input logic                 em_wr,
                                        input logic                 em_ld,
                                        input logic [REG_IDX_W-1:0] em_dest,
                                        input logic                 mw_vld,
                                        input logic                 mw_wr,
                                        input logic [REG_IDX_W-1:0] mw_dest);
    if (FWD_EN == 0) begin
      return FWD_RF;
    end else if (em_vld && em_wr && !em_ld && idx_hit(src, em_dest)) begin
      return FWD_EX_MEM;
    end else if (mw_vld && mw_wr && idx_hit(src, mw_dest)) begin
      return FWD_MEM_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

  assign mem_access_s = ex_mem_valid && (ex_mem_rd_mem || ex_mem_wr_mem);

  // Memory wait-state sequencer; rem counts the stall cycles still owed after this one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      rem_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_access_s && (MEM_LAT > 1)) begin
            state_r <= WAIT;
            rem_r   <= REM_INIT;
          end else begin
            state_r <= IDLE;
            rem_r   <= rem_r;
          end
        end
        WAIT: begin
          if (rem_r != '0) begin
            state_r <= WAIT;
            rem_r   <= rem_r - REM_W'(1);
          end else begin
            state_r <= IDLE;
            rem_r   <= rem_r;
          end
        end
        default: begin
          state_r <= IDLE;
          rem_r   <= '0;
        end
      endcase
    end
  end

  // Wait-state indication, combinational from FSM state and the current access
  always_comb begin
    mem_stall_s = 1'b0;
    if (MEM_LAT <= 1) begin
      mem_stall_s = 1'b0;
    end else if (state_r == IDLE) begin
      mem_stall_s = mem_access_s;
    end else begin
      mem_stall_s = (rem_r != '0);
    end
  end

  // Hazard classification and priority: mem wait state, then branch, then RAW stall
  always_comb begin
    load_use_s = id_ex_valid && id_ex_rd_mem && id_ex_reg_wr &&
                 src_hit(if_id_valid, if_id_rs1_idx, if_id_rs1_used,
                         if_id_rs2_idx, if_id_rs2_used, id_ex_dest_idx);
    raw_s = 1'b0;
    if (FWD_EN == 0) begin
      raw_s = (id_ex_valid && id_ex_reg_wr &&
               src_hit(if_id_valid, if_id_rs1_idx, if_id_rs1_used,
                       if_id_rs2_idx, if_id_rs2_used, id_ex_dest_idx)) ||
              (ex_mem_valid && ex_mem_reg_wr &&
               src_hit(if_id_valid, if_id_rs1_idx, if_id_rs1_used,
                       if_id_rs2_idx, if_id_rs2_used, ex_mem_dest_idx));
    end else begin
      raw_s = 1'b0;
    end
    branch_s   = ex_take_branch && id_ex_valid && !mem_stall_s;
    hz_stall_s = (load_use_s || raw_s) && !branch_s && !mem_stall_s;
  end

  // Pipeline register controls
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (mem_stall_s) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_s) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hz_stall_s) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  assign mem_stall = mem_stall_s;
  assign fwd_a_sel = fwd_pick(id_ex_rs1_idx, ex_mem_valid, ex_mem_reg_wr, ex_mem_rd_mem,
                              ex_mem_dest_idx, mem_wb_valid, mem_wb_reg_wr, mem_wb_dest_idx);
  assign fwd_b_sel = fwd_pick(id_ex_rs2_idx, ex_mem_valid, ex_mem_reg_wr, ex_mem_rd_mem,
                              ex_mem_dest_idx, mem_wb_valid, mem_wb_reg_wr, mem_wb_dest_idx);

  sat_counter #(.W(CNT_W)) u_cnt_cycles (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(1'b1), .q(cnt_cycles)
  );
  sat_counter #(.W(CNT_W)) u_cnt_retired (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(mem_wb_valid), .q(cnt_retired)
  );
  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(mem_stall_s || hz_stall_s), .q(cnt_stall)
  );
  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(branch_s), .q(cnt_flush)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: three configurations (MEM_LAT 3/2/1, FWD_EN 1/1/0)
// share one directed stimulus stream; a negedge monitor drains the expectation queue.
module tb_pipe_ctrl;

  localparam int N  = 3;
  localparam int CW = 8;
  localparam int RW = 5;

  // {pc,if_id_en,id_ex_en,ex_mem_en, if_flush,id_flush,bubble,mem_stall, fwd_a[1:0], fwd_b[1:0]}
  localparam logic [11:0] NORM  = 12'b1111_0000_0000;
  localparam logic [11:0] MSTL  = 12'b0000_0011_0000;
  localparam logic [11:0] BRAN  = 12'b1111_1100_0000;
  localparam logic [11:0] RAWS  = 12'b0011_0100_0000;
  localparam logic [11:0] FA_EM = 12'b1111_0000_0100;
  localparam logic [11:0] FA_MW = 12'b1111_0000_1000;
  localparam logic [11:0] FB_MW = 12'b1111_0000_0010;

  logic clk = 1'b0;
  logic rst;
  logic [RW-1:0] if_id_rs1_idx, if_id_rs2_idx, id_ex_rs1_idx, id_ex_rs2_idx, id_ex_dest_idx;
  logic [RW-1:0] ex_mem_dest_idx, mem_wb_dest_idx;
  logic if_id_rs1_used, if_id_rs2_used, if_id_valid;
  logic id_ex_reg_wr, id_ex_rd_mem, id_ex_valid, ex_take_branch;
  logic ex_mem_reg_wr, ex_mem_rd_mem, ex_mem_wr_mem, ex_mem_valid;
  logic mem_wb_reg_wr, mem_wb_valid, cnt_clr;

  logic          pc_en_w [N], if_id_en_w [N], id_ex_en_w [N], ex_mem_en_w [N];
  logic          if_id_flush_w [N], id_ex_flush_w [N], mem_wb_bubble_w [N], mem_stall_w [N];
  logic [1:0]    fwd_a_w [N], fwd_b_w [N];
  logic [CW-1:0] cyc_w [N], ret_w [N], stl_w [N], flu_w [N];

  typedef struct {
    string         name;
    int            inst;
    bit            is_cnt;
    int            sel;
    logic [11:0]   ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    pipe_ctrl #(
      .REG_IDX_W(RW),
      .MEM_LAT  (g == 0 ? 3 : (g == 1 ? 2 : 1)),
      .FWD_EN   (g == 2 ? 0 : 1),
      .CNT_W    (CW)
    ) dut (
      .clk(clk), .rst(rst),
      .if_id_rs1_idx(if_id_rs1_idx), .if_id_rs2_idx(if_id_rs2_idx),
      .if_id_rs1_used(if_id_rs1_used), .if_id_rs2_used(if_id_rs2_used),
      .if_id_valid(if_id_valid),
      .id_ex_rs1_idx(id_ex_rs1_idx), .id_ex_rs2_idx(id_ex_rs2_idx),
      .id_ex_dest_idx(id_ex_dest_idx), .id_ex_reg_wr(id_ex_reg_wr),
      .id_ex_rd_mem(id_ex_rd_mem), .id_ex_valid(id_ex_valid),
      .ex_take_branch(ex_take_branch),
      .ex_mem_dest_idx(ex_mem_dest_idx), .ex_mem_reg_wr(ex_mem_reg_wr),
      .ex_mem_rd_mem(ex_mem_rd_mem), .ex_mem_wr_mem(ex_mem_wr_mem),
      .ex_mem_valid(ex_mem_valid),
      .mem_wb_dest_idx(mem_wb_dest_idx), .mem_wb_reg_wr(mem_wb_reg_wr),
      .mem_wb_valid(mem_wb_valid), .cnt_clr(cnt_clr),
      .pc_en(pc_en_w[g]), .if_id_en(if_id_en_w[g]), .id_ex_en(id_ex_en_w[g]),
      .ex_mem_en(ex_mem_en_w[g]), .if_id_flush(if_id_flush_w[g]),
      .id_ex_flush(id_ex_flush_w[g]), .mem_wb_bubble(mem_wb_bubble_w[g]),
      .fwd_a_sel(fwd_a_w[g]), .fwd_b_sel(fwd_b_w[g]), .mem_stall(mem_stall_w[g]),
      .cnt_cycles(cyc_w[g]), .cnt_retired(ret_w[g]),
      .cnt_stall(stl_w[g]), .cnt_flush(flu_w[g])
    );
  end

  function automatic logic [11:0] get_ctl(input int i);
    return {pc_en_w[i], if_id_en_w[i], id_ex_en_w[i], ex_mem_en_w[i],
            if_id_flush_w[i], id_ex_flush_w[i], mem_wb_bubble_w[i], mem_stall_w[i],
            fwd_a_w[i], fwd_b_w[i]};
  endfunction

  function automatic logic [CW-1:0] get_cnt(input int i, input int sel);
    case (sel)
      0:       return cyc_w[i];
      1:       return ret_w[i];
      2:       return stl_w[i];
      default: return flu_w[i];
    endcase
  endfunction

  // Monitor: every negedge, compare all expectations queued for this cycle
  initial begin
    exp_t          e;
    logic [11:0]   act_c;
    logic [CW-1:0] act_n;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        vectors++;
        if (!e.is_cnt) begin
          act_c = get_ctl(e.inst);
          if (act_c !== e.ctl) begin
            miscompares++;
            $display("FAIL %s inst%0d ctl: got %b expected %b", e.name, e.inst, act_c, e.ctl);
          end
        end else begin
          act_n = get_cnt(e.inst, e.sel);
          if (act_n !== e.cnt) begin
            miscompares++;
            $display("FAIL %s inst%0d cnt%0d: got %0d expected %0d",
                     e.name, e.inst, e.sel, act_n, e.cnt);
          end
        end
      end
    end
  end

  task automatic exp_ctl(input string nm, input int inst, input logic [11:0] v);
    exp_t e;
    e.name = nm; e.inst = inst; e.is_cnt = 1'b0; e.sel = 0; e.ctl = v; e.cnt = '0;
    sbq.push_back(e);
  endtask

  // sel: 0 cycles, 1 retired, 2 stall, 3 flush
  task automatic exp_cnt(input string nm, input int inst, input int sel, input logic [CW-1:0] v);
    exp_t e;
    e.name = nm; e.inst = inst; e.is_cnt = 1'b1; e.sel = sel; e.ctl = '0; e.cnt = v;
    sbq.push_back(e);
  endtask

  task automatic idle();
    if_id_rs1_idx = '0; if_id_rs2_idx = '0; if_id_rs1_used = 1'b0; if_id_rs2_used = 1'b0;
    if_id_valid = 1'b0; id_ex_rs1_idx = '0; id_ex_rs2_idx = '0; id_ex_dest_idx = '0;
    id_ex_reg_wr = 1'b0; id_ex_rd_mem = 1'b0; id_ex_valid = 1'b0; ex_take_branch = 1'b0;
    ex_mem_dest_idx = '0; ex_mem_reg_wr = 1'b0; ex_mem_rd_mem = 1'b0; ex_mem_wr_mem = 1'b0;
    ex_mem_valid = 1'b0; mem_wb_dest_idx = '0; mem_wb_reg_wr = 1'b0; mem_wb_valid = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic mem_load();
    ex_mem_valid = 1'b1; ex_mem_rd_mem = 1'b1; ex_mem_reg_wr = 1'b1; ex_mem_dest_idx = 5'd5;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    for (int i = 0; i < N; i++) begin
      exp_ctl("reset", i, NORM);
      exp_cnt("reset_cyc", i, 0, 8'd0);
      exp_cnt("reset_stl", i, 2, 8'd0);
    end
    next_cycle(); rst = 1'b0; cnt_clr = 1'b1;

    // Load in EX/MEM held across three cycles
    next_cycle(); mem_load();
    exp_ctl("lat_c0", 0, MSTL); exp_ctl("lat_c0", 1, MSTL); exp_ctl("lat_c0", 2, NORM);
    exp_cnt("lat_cyc0", 0, 0, 8'd0);
    next_cycle(); mem_load();
    exp_ctl("lat_c1", 0, MSTL); exp_ctl("lat_c1", 1, NORM); exp_ctl("lat_c1", 2, NORM);
    next_cycle(); mem_load();
    exp_ctl("lat_c2", 0, NORM); exp_ctl("lat_b2b", 1, MSTL);
    next_cycle();
    exp_ctl("lat_done", 0, NORM); exp_ctl("lat_done", 1, NORM);
    exp_cnt("lat_stl", 0, 2, 8'd2); exp_cnt("lat_cyc", 0, 0, 8'd3);
    exp_cnt("b2b_stl", 1, 2, 8'd2);

    // Load-use x5 then consumer forwarded from MEM/WB
    next_cycle();
    id_ex_valid = 1'b1; id_ex_rd_mem = 1'b1; id_ex_reg_wr = 1'b1; id_ex_dest_idx = 5'd5;
    if_id_valid = 1'b1; if_id_rs1_idx = 5'd5; if_id_rs1_used = 1'b1;
    for (int i = 0; i < N; i++) exp_ctl("load_use", i, RAWS);
    next_cycle();
    id_ex_valid = 1'b1; id_ex_rs1_idx = 5'd5;
    mem_wb_valid = 1'b1; mem_wb_reg_wr = 1'b1; mem_wb_dest_idx = 5'd5;
    exp_ctl("lu_fwd", 0, FA_MW); exp_ctl("lu_fwd", 1, FA_MW); exp_ctl("lu_nofwd", 2, NORM);

    // Newer producer wins, x0 never forwards, non-writer skipped
    next_cycle();
    id_ex_valid = 1'b1; id_ex_rs1_idx = 5'd3; id_ex_rs2_idx = 5'd4;
    ex_mem_valid = 1'b1; ex_mem_reg_wr = 1'b1; ex_mem_dest_idx = 5'd3;
    mem_wb_valid = 1'b1; mem_wb_reg_wr = 1'b1; mem_wb_dest_idx = 5'd3;
    exp_ctl("fwd_newer", 0, FA_EM); exp_ctl("fwd_off", 2, NORM);
    next_cycle();
    id_ex_valid = 1'b1;
    ex_mem_valid = 1'b1; ex_mem_reg_wr = 1'b1;
    mem_wb_valid = 1'b1; mem_wb_reg_wr = 1'b1;
    exp_ctl("fwd_x0", 0, NORM);
    next_cycle();
    id_ex_valid = 1'b1; id_ex_rs2_idx = 5'd6;
    ex_mem_valid = 1'b1; ex_mem_dest_idx = 5'd6;
    mem_wb_valid = 1'b1; mem_wb_reg_wr = 1'b1; mem_wb_dest_idx = 5'd6;
    exp_ctl("fwd_b_mw", 0, FB_MW);

    // Branch beats load-use
    next_cycle(); cnt_clr = 1'b1;
    next_cycle();
    id_ex_valid = 1'b1; id_ex_rd_mem = 1'b1; id_ex_reg_wr = 1'b1; id_ex_dest_idx = 5'd5;
    ex_take_branch = 1'b1;
    if_id_valid = 1'b1; if_id_rs2_idx = 5'd5; if_id_rs2_used = 1'b1;
    for (int i = 0; i < N; i++) exp_ctl("br_lu", i, BRAN);
    next_cycle();
    exp_cnt("br_flu", 0, 3, 8'd1); exp_cnt("br_stl", 0, 2, 8'd0); exp_cnt("br_cyc", 0, 0, 8'd1);

    // Branch during mem wait state re-resolves after it
    next_cycle(); mem_load(); id_ex_valid = 1'b1; ex_take_branch = 1'b1;
    exp_ctl("br_ms0", 0, MSTL); exp_ctl("br_ms0", 1, MSTL); exp_ctl("br_ms0", 2, BRAN);
    next_cycle(); mem_load(); id_ex_valid = 1'b1; ex_take_branch = 1'b1;
    exp_ctl("br_ms1", 0, MSTL); exp_ctl("br_ms1", 1, BRAN); exp_ctl("br_ms1", 2, BRAN);
    next_cycle();
    exp_ctl("br_ms2", 0, NORM);
    exp_cnt("br_ms_flu", 0, 3, 8'd1); exp_cnt("br_ms_flu", 1, 3, 8'd2);
    exp_cnt("br_ms_flu", 2, 3, 8'd3);
    exp_cnt("br_ms_stl", 0, 2, 8'd2); exp_cnt("br_ms_stl", 1, 2, 8'd1);

    // Forwarding disabled: RAW on EX/MEM and ID/EX writers
    next_cycle();
    if_id_valid = 1'b1; if_id_rs1_idx = 5'd7; if_id_rs1_used = 1'b1;
    id_ex_valid = 1'b1; id_ex_rs1_idx = 5'd7;
    ex_mem_valid = 1'b1; ex_mem_reg_wr = 1'b1; ex_mem_dest_idx = 5'd7;
    exp_ctl("nofwd_em", 2, RAWS); exp_ctl("fwd_em", 0, FA_EM);
    next_cycle();
    if_id_valid = 1'b1; if_id_rs1_used = 1'b1;
    ex_mem_valid = 1'b1; ex_mem_reg_wr = 1'b1;
    exp_ctl("nofwd_x0", 2, NORM);
    next_cycle();
    if_id_valid = 1'b1; if_id_rs2_idx = 5'd9; if_id_rs2_used = 1'b1;
    id_ex_valid = 1'b1; id_ex_reg_wr = 1'b1; id_ex_dest_idx = 5'd9;
    exp_ctl("nofwd_ie", 2, RAWS); exp_ctl("fwd_ie", 0, NORM);

    // Reset while in WAIT
    next_cycle(); mem_load();
    exp_ctl("rst_pre", 0, MSTL);
    next_cycle(); rst = 1'b1;
    exp_ctl("rst_wait", 0, NORM); exp_cnt("rst_cyc", 0, 0, 8'd0); exp_cnt("rst_flu", 2, 3, 8'd0);
    next_cycle(); rst = 1'b0;
    exp_ctl("rst_idle", 0, NORM);

    // Retired count, then saturation and clear against a saturating increment
    for (int k = 0; k < 3; k++) begin
      next_cycle(); mem_wb_valid = 1'b1;
    end
    next_cycle();
    exp_cnt("ret", 0, 1, 8'd3); exp_cnt("ret_cyc", 0, 0, 8'd4);
    for (int k = 0; k < 300; k++) next_cycle();
    cnt_clr = 1'b1;
    exp_cnt("sat_cyc", 0, 0, 8'hFF); exp_cnt("sat_ret", 0, 1, 8'd3);
    next_cycle();
    exp_cnt("clr_sat", 0, 0, 8'd0); exp_cnt("clr_ret", 0, 1, 8'd0);

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
